// File: rtl/maxpool_seq_ctrl.sv
// rtl/maxpool_seq_ctrl.sv - 2x2 stride-2 max-pool sequencer time-sharing one external pairwise-max array
// Optional feature macro: MAXPOOL_RELU_EN (clamp negative pooled channels to zero on output load).
`timescale 1ns/1ps
module maxpool_seq_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_MODULES = 16,
  parameter int IFM_WIDTH   = 416,
  parameter int IFM_HEIGHT  = 416
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0]   in_data,
  output logic [2*DATA_WIDTH*NUM_MODULES-1:0] mp_pair,
  input  logic [DATA_WIDTH*NUM_MODULES-1:0]   mp_max,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_WIDTH*NUM_MODULES-1:0]   out_data
);
  localparam int PW       = DATA_WIDTH * NUM_MODULES;
  localparam int CW       = (IFM_WIDTH > 4) ? $clog2(IFM_WIDTH) : 2;
  localparam int RW       = (IFM_HEIGHT > 2) ? $clog2(IFM_HEIGHT) : 1;
  localparam int IW       = CW - 1;
  localparam int LB_DEPTH = IFM_WIDTH / 2;
  localparam logic [CW-1:0] COL_LAST = CW'(IFM_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IFM_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [PW-1:0]   r_hold_even;
  logic [PW-1:0]   r_hmax;
  logic [PW-1:0]   r_out_data;
  logic [PW-1:0]   r_linebuf [LB_DEPTH];
  logic [IW-1:0]   r_vidx;
  logic            r_vpend;
  logic            r_out_valid;
  logic            r_busy;
  logic            r_done;

  logic            w_stall;
  logic            w_in_ready;
  logic            w_acc;
  logic            w_hop;
  logic            w_vop;
  logic            w_last_px;
  logic [PW-1:0]   w_op_a;
  logic [PW-1:0]   w_op_b;
  logic [PW-1:0]   w_out_next;
  logic [2*PW-1:0] w_pair;

  // A pending vertical op may only fire when the output register can take its result.
  assign w_stall    = r_vpend && r_out_valid && !out_ready;
  assign w_in_ready = (r_state == S_RUN) && !w_stall;
  assign w_acc      = in_valid && w_in_ready;
  assign w_hop      = w_acc && r_col[0];
  assign w_vop      = r_vpend && (!r_out_valid || out_ready);
  assign w_last_px  = (r_col == COL_LAST) && (r_row == ROW_LAST);

  // Horizontal and vertical ops cannot coincide: the pixel after an odd column is always even.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    if (w_hop) begin
      w_op_a = r_hold_even;
      w_op_b = in_data;
    end else if (w_vop) begin
      w_op_a = r_linebuf[r_vidx];
      w_op_b = r_hmax;
    end
  end

  always_comb begin
    w_pair = '0;
    for (int i = 0; i < NUM_MODULES; i++) begin
      w_pair[(2*i)*DATA_WIDTH   +: DATA_WIDTH] = w_op_a[i*DATA_WIDTH +: DATA_WIDTH];
      w_pair[(2*i+1)*DATA_WIDTH +: DATA_WIDTH] = w_op_b[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_out_next = mp_max;
`ifdef MAXPOOL_RELU_EN
    for (int i = 0; i < NUM_MODULES; i++) begin
      if (mp_max[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
        w_out_next[i*DATA_WIDTH +: DATA_WIDTH] = '0;
      end
    end
`endif
  end

  // Line buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge clk) begin
    if (w_hop && !r_row[0]) begin
      r_linebuf[r_col[CW-1:1]] <= mp_max;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_col       <= '0;
      r_row       <= '0;
      r_hold_even <= '0;
      r_hmax      <= '0;
      r_out_data  <= '0;
      r_vidx      <= '0;
      r_vpend     <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_acc && !r_col[0]) begin
        r_hold_even <= in_data;
      end

      if (w_hop && r_row[0]) begin
        r_hmax  <= mp_max;
        r_vidx  <= r_col[CW-1:1];
        r_vpend <= 1'b1;
      end else if (w_vop) begin
        r_vpend <= 1'b0;
      end

      if (w_vop) begin
        r_out_data  <= w_out_next;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_acc) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
            r_col   <= '0;
            r_row   <= '0;
          end
        end
        S_RUN: begin
          if (w_acc && w_last_px) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!r_vpend && (!r_out_valid || out_ready)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = w_in_ready;
  assign mp_pair   = w_pair;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// tb/tb_maxpool_seq_ctrl.sv - scoreboard bench for maxpool_seq_ctrl on a 4x4, 2-channel map
`timescale 1ns/1ps
module tb_maxpool_seq_ctrl;
  localparam int DW = 16;
  localparam int NM = 2;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = DW * NM;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            busy;
  logic            done;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [PW-1:0]   in_data = '0;
  logic [2*PW-1:0] mp_pair;
  logic [PW-1:0]   mp_max;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [PW-1:0]   out_data;

  int n_checks = 0;
  int n_errors = 0;
  logic [PW-1:0] exp_q[$];
  logic signed [DW-1:0] img0 [W*H];
  logic signed [DW-1:0] img1 [W*H];

  always #5 clk = ~clk;

  maxpool_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_MODULES(NM), .IFM_WIDTH(W), .IFM_HEIGHT(H)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mp_pair(mp_pair), .mp_max(mp_max),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // External pairwise signed max array.
  always_comb begin
    mp_max = '0;
    for (int i = 0; i < NM; i++) begin
      mp_max[i*DW +: DW] = ($signed(mp_pair[(2*i)*DW +: DW]) > $signed(mp_pair[(2*i+1)*DW +: DW]))
                           ? mp_pair[(2*i)*DW +: DW] : mp_pair[(2*i+1)*DW +: DW];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] exp_px(input int c0, input int c1);
    logic signed [DW-1:0] v0;
    logic signed [DW-1:0] v1;
    v0 = DW'(c0);
    v1 = DW'(c1);
`ifdef MAXPOOL_RELU_EN
    if (v0 < 0) v0 = '0;
    if (v1 < 0) v1 = '0;
`endif
    return {v1, v0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got %0h expected none", out_data);
      end else begin
        check("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic send_pixel(input int idx, input bit chk_pair, input bit gap);
    int t;
    in_data  = {img1[idx], img0[idx]};
    in_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_accept_timeout: got in_ready=0 expected 1 at pixel %0d", idx);
    end
    if (chk_pair) begin
      check("pair_a_ch0", mp_pair[DW-1:0], 64'd3);
      check("pair_b_ch0", mp_pair[2*DW-1:DW], 64'd9);
    end
    @(posedge clk); #1;
    if (gap) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    @(negedge clk);
    while (!done && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL done_timeout: got done=0 expected 1");
    end else begin
      check("queue_empty_at_done", exp_q.size(), 64'd0);
      @(negedge clk);
      check("done_single_pulse", done, 64'd0);
      check("busy_after_done", busy, 64'd0);
    end
  endtask

  task automatic run_frame(input bit pair_chk, input bit gap);
    do_start();
    check("busy_at_start", busy, 64'd1);
    for (int i = 0; i < W*H; i++) begin
      send_pixel(i, pair_chk && (i == 1), gap);
    end
    in_valid = 1'b0;
    wait_done();
  endtask

  task automatic load_ramp();
    for (int i = 0; i < W*H; i++) begin
      img0[i] = DW'(i);
      img1[i] = DW'(-i);
    end
  endtask

  task automatic push_ramp();
    exp_q.push_back(exp_px(5, 0));
    exp_q.push_back(exp_px(7, -2));
    exp_q.push_back(exp_px(13, -8));
    exp_q.push_back(exp_px(15, -10));
  endtask

  initial begin
    logic [PW-1:0] held;
    int t;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_in_ready", in_ready, 64'd0);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_mp_pair", mp_pair, 64'd0);
    rst_n = 1'b1;

    // Abort a frame mid-RUN with reset.
    load_ramp();
    do_start();
    check("busy_first_start", busy, 64'd1);
    check("in_ready_first_start", in_ready, 64'd1);
    for (int i = 0; i < 3; i++) send_pixel(i, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 64'd0);
    check("midrst_in_ready", in_ready, 64'd0);
    check("midrst_out_valid", out_valid, 64'd0);
    check("midrst_out_data", out_data, 64'd0);
    check("midrst_mp_pair", mp_pair, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Raster ramp.
    push_ramp();
    run_frame(1'b0, 1'b0);

    // Pair packing.
    for (int i = 0; i < W*H; i++) begin
      img0[i] = '0;
      img1[i] = '0;
    end
    img0[0] = 16'sd3; img0[1] = 16'sd9; img0[2] = 16'sd1; img0[3] = 16'sd1;
    img0[4] = 16'sd2; img0[5] = 16'sd2; img0[6] = 16'sd8; img0[7] = 16'sd0;
    exp_q.push_back(exp_px(9, 0));
    exp_q.push_back(exp_px(8, 0));
    exp_q.push_back(exp_px(0, 0));
    exp_q.push_back(exp_px(0, 0));
    run_frame(1'b1, 1'b0);

    // Backpressure at the first output.
    load_ramp();
    push_ramp();
    out_ready = 1'b0;
    fork
      run_frame(1'b0, 1'b0);
      begin
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("bp_first_valid", out_valid, 64'd1);
        held = out_data;
        repeat (5) begin
          @(negedge clk);
          check("bp_out_data_stable", out_data, held);
        end
        check("bp_in_ready_low", in_ready, 64'd0);
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join

    // Gapped input.
    push_ramp();
    run_frame(1'b0, 1'b1);

    check("final_queue_empty", exp_q.size(), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maxpool_seq_ctrl.md
# maxpool_seq_ctrl

Sequencer for 2×2, stride-2 max pooling over a streamed feature map. It accepts one pixel per cycle, where a pixel is all NUM_MODULES channels of one (row, col) position, and time-shares a single external pairwise-max array between horizontal and vertical reductions. A half-width line buffer holds the horizontal maxima of each even row. The block sits between the conv output stream and the next layer's input buffer, and owns the pair bus into the max array.

## Interface
- DATA_WIDTH, 16, signed bits per channel value
- NUM_MODULES, 16, channels per pixel (= max-array lanes)
- IFM_WIDTH, 416, input columns; must be even
- IFM_HEIGHT, 416, input rows; must be even
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle pulse after the last pooled pixel is accepted downstream
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH*NUM_MODULES  pixel, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
- mp_pair  out  2*DATA_WIDTH*NUM_MODULES  to max array; channel i operand A at slice 2i, operand B at slice 2i+1
- mp_max  in  DATA_WIDTH*NUM_MODULES  from max array (combinational), channel i at slice i
- out_valid  out  1  pooled pixel valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH*NUM_MODULES  pooled pixel, same packing as in_data

## Operation
- FSM states:
  - IDLE: start goes to RUN and clears the counters.
  - RUN: after the last input pixel is accepted, go to FLUSH.
  - FLUSH: when no vertical operation is pending and the output register is empty or being accepted, go to DONE.
  - DONE: pulses done for one cycle, then goes to IDLE.
- start outside IDLE is ignored.
- Counters: col 0..IFM_WIDTH-1 and row 0..IFM_HEIGHT-1 advance on each accepted input. col wraps to 0 and increments row.
- Even col: register the pixel in hold_even. No array use.
- Odd col (horizontal op, same cycle): mp_pair A = hold_even, B = in_data. The result is captured on that edge.
  - Even row: the result is written to linebuf[col>>1].
  - Odd row: the result goes to hmax_reg and sets vpend.
- vpend cycle (vertical op): mp_pair A = linebuf[idx], B = hmax_reg. The result is loaded into out_data, out_valid is set, and vpend is cleared.
- Horizontal and vertical ops are never in the same cycle, because the cycle after an odd col is always an even col. The select is exclusive.
- When neither op is active, mp_pair = 0.
- in_ready = (state==RUN) && !(vpend && out_valid && !out_ready). The same-cycle even-col input is accepted alongside the vertical op.
- out_valid clears on out_valid && out_ready unless it is reloaded in the same cycle.
- Output count per frame: (IFM_WIDTH/2)*(IFM_HEIGHT/2), in raster order.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_data=0, mp_pair=0, state=IDLE.
- start at edge E: busy=1 and in_ready=1 from E+1.
- Latency: accept odd-row/odd-col pixel at edge T → vertical op in cycle T+1 → out_valid=1 from edge T+1 (visible cycle T+2). No stall assumed.
- Backpressure: while out_valid && !out_ready with vpend, in_ready=0 and vpend holds.
- Last pixel accepted at edge T: done pulses no earlier than the cycle after the final out_valid && out_ready. busy falls together with done.
- Reset mid-frame: all state clears immediately. The line buffer content is don't-care and not reused.

## Configuration
- MAXPOOL_RELU_EN:
  - Defined: out_data channels that are negative (MSB set) load as 0.
  - Undefined: out_data = mp_max unmodified.
  - mp_pair and the line buffer are unaffected either way.

## Test plan
All scenarios use IFM_WIDTH=4, IFM_HEIGHT=4, NUM_MODULES=2, out_ready=1 unless stated.
- Reset/idle: assert rst_n=0 mid-RUN → all outputs at reset values next cycle. start after release → busy=1.
- Raster ramp:
  - Stimulus: ch0 = r*4+c, ch1 = -(r*4+c).
  - Required response: 4 outputs, ch0 = 5,7,13,15 and ch1 = 0,-2,-8,-10. done pulses once.
- Pair packing: row0 = {3,9,1,1}, row1 = {2,2,8,0} on ch0 → mp_pair ch0 slices A=3, B=9 on the col1 accept cycle, and outputs 9 then 8.
- Backpressure: out_ready=0 for 5 cycles at first output → out_data stable, in_ready=0 while vpend, no pixel lost. Outputs identical to the ramp case.
- Gapped input: in_valid toggles every other cycle → same 4 outputs. done only after the last output is accepted.
- MAXPOOL_RELU_EN defined with the ramp → ch1 outputs 0,0,0,0 and ch0 unchanged.
